// File: rtl/tlp_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlp_link_arbiter
// Purpose  : Shares one TX->RX data-link channel between a write-TLP source
//            and a read-TLP source. Whole packets are granted (no beat
//            interleaving), the number of unacknowledged TLPs is bounded by
//            MAX_OUTSTANDING, and a tag FIFO records the source of every
//            launched TLP so each ack/nack is routed back to its owner.
//
// Ports    : clk, reset_n            clock, asynchronous active-low reset
//            wr_tlp_* / rd_tlp_*     source beat streams (data/valid/last in,
//                                    ready out)
//            tlp_data/tlp_valid      link beat towards RX
//            tlp_ready               RX beat acceptance
//            ack / nack              retire pulses for the oldest TLP
//            wr_done/wr_nack,
//            rd_done/rd_nack         per-owner retire pulses
//            outstanding             in-flight TLP count
//            spurious_err            ack/nack seen with nothing in flight
//
// Options  : TLP_ARB_WR_PRIO_EN      when defined, write strictly wins over
//                                    read in IDLE; otherwise round-robin.
//
// Revision : 1.0  initial release
// ============================================================================
module tlp_link_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    // write-path source
    input  logic [DATA_WIDTH-1:0]              wr_tlp_data,
    input  logic                               wr_tlp_valid,
    input  logic                               wr_tlp_last,
    output logic                               wr_tlp_ready,
    // read-path source
    input  logic [DATA_WIDTH-1:0]              rd_tlp_data,
    input  logic                               rd_tlp_valid,
    input  logic                               rd_tlp_last,
    output logic                               rd_tlp_ready,
    // link towards RX
    output logic [DATA_WIDTH-1:0]              tlp_data,
    output logic                               tlp_valid,
    input  logic                               tlp_ready,
    // retire interface
    input  logic                               ack,
    input  logic                               nack,
    output logic                               wr_done,
    output logic                               rd_done,
    output logic                               wr_nack,
    output logic                               rd_nack,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               spurious_err
);

    localparam int                  c_PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic                c_TAG_WR  = 1'b0;
    localparam logic                c_TAG_RD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     r_state_q,      w_state_d;
    logic                       r_first_beat_q, w_first_beat_d;
    logic                       r_last_rd_q,    w_last_rd_d;
    logic [MAX_OUTSTANDING-1:0] r_tag_mem_q,    w_tag_mem_d;
    logic [c_PTR_W-1:0]         r_wr_ptr_q,     w_wr_ptr_d;
    logic [c_PTR_W-1:0]         r_rd_ptr_q,     w_rd_ptr_d;
    logic [c_CNT_W-1:0]         r_count_q,      w_count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic w_beat_xfer;
    logic w_beat_last;
    logic w_launch;
    logic w_launch_tag;
    logic w_retire_req;
    logic w_fifo_empty;
    logic w_retire;
    logic w_head_tag;
    logic w_has_credit;
    logic w_any_req;
    logic w_pick_rd;

    // ------------------------------------------------------------------
    // Link datapath: a straight mux of the granted source. The non-granted
    // source always sees ready low so it cannot lose a beat.
    // ------------------------------------------------------------------
    always_comb begin
        tlp_valid    = 1'b0;
        tlp_data     = '0;
        wr_tlp_ready = 1'b0;
        rd_tlp_ready = 1'b0;
        w_beat_last  = 1'b0;
        case (r_state_q)
            ST_WR_BURST: begin
                tlp_valid    = wr_tlp_valid;
                tlp_data     = wr_tlp_data;
                wr_tlp_ready = tlp_ready;
                w_beat_last  = wr_tlp_last;
            end
            ST_RD_BURST: begin
                tlp_valid    = rd_tlp_valid;
                tlp_data     = rd_tlp_data;
                rd_tlp_ready = tlp_ready;
                w_beat_last  = rd_tlp_last;
            end
            default: ;
        endcase
    end

    assign w_beat_xfer  = tlp_valid & tlp_ready;
    // A TLP counts as launched on its first accepted beat, not at grant.
    assign w_launch     = w_beat_xfer & r_first_beat_q;
    assign w_launch_tag = (r_state_q == ST_RD_BURST) ? c_TAG_RD : c_TAG_WR;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_has_credit = (r_count_q < c_MAX_CNT);
    assign w_any_req    = wr_tlp_valid | rd_tlp_valid;

`ifdef TLP_ARB_WR_PRIO_EN
    // Strict priority: read only wins when write is not requesting.
    assign w_pick_rd = ~wr_tlp_valid;
`else
    // Round-robin: with both requesting, take the one not granted last.
    assign w_pick_rd = rd_tlp_valid & (~wr_tlp_valid | ~r_last_rd_q);
`endif

    // ------------------------------------------------------------------
    // FSM next state. A burst always returns to IDLE after its last beat,
    // which guarantees one idle cycle between packets and lets the credit
    // count settle before the next grant decision.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_first_beat_d = r_first_beat_q;
        w_last_rd_d    = r_last_rd_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_has_credit && w_any_req) begin
                    w_state_d      = w_pick_rd ? ST_RD_BURST : ST_WR_BURST;
                    w_first_beat_d = 1'b1;
                    w_last_rd_d    = w_pick_rd;
                end
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (w_beat_xfer) begin
                    w_first_beat_d = 1'b0;
                    if (w_beat_last) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Retire path. The head tag comes straight from the registered FIFO, so
    // the owner pulse is produced in the same cycle as ack/nack. A
    // simultaneous ack and nack retires one TLP, reported as a nack.
    // ------------------------------------------------------------------
    assign w_retire_req = ack | nack;
    assign w_fifo_empty = (r_count_q == '0);
    assign w_retire     = w_retire_req & ~w_fifo_empty;
    assign w_head_tag   = r_tag_mem_q[r_rd_ptr_q];

    assign wr_done      = w_retire & ~nack & (w_head_tag == c_TAG_WR);
    assign wr_nack      = w_retire &  nack & (w_head_tag == c_TAG_WR);
    assign rd_done      = w_retire & ~nack & (w_head_tag == c_TAG_RD);
    assign rd_nack      = w_retire &  nack & (w_head_tag == c_TAG_RD);
    // Gated so that every output reads 0 while reset is held.
    assign spurious_err = w_retire_req & w_fifo_empty & reset_n;
    assign outstanding  = r_count_q;

    // ------------------------------------------------------------------
    // Tag FIFO and credit count. The count doubles as the FIFO occupancy.
    // A launch can never meet a full FIFO: grants require spare credit and
    // only one packet is ever in burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_tag_mem_d = r_tag_mem_q;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_count_d   = r_count_q;
        if (w_launch) begin
            w_tag_mem_d[r_wr_ptr_q] = w_launch_tag;
            w_wr_ptr_d              = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_retire) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_launch, w_retire})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q      <= ST_IDLE;
            r_first_beat_q <= 1'b0;
            // "Last granted = read" makes the first contested grant go to write.
            r_last_rd_q    <= 1'b1;
            r_tag_mem_q    <= '0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_first_beat_q <= w_first_beat_d;
            r_last_rd_q    <= w_last_rd_d;
            r_tag_mem_q    <= w_tag_mem_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlp_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_link_arbiter
// Purpose  : Self-checking bench for tlp_link_arbiter (MAX_OUTSTANDING=4).
//            Directed scenarios plus a randomized run checked against a
//            packet/tag-queue reference model. Source data carries its
//            origin in bit 31 (0 = write, 1 = read).
// Revision : 1.0  initial release
// ============================================================================
module tb_tlp_link_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wr_tlp_data, rd_tlp_data, tlp_data;
    logic        wr_tlp_valid, wr_tlp_last, wr_tlp_ready;
    logic        rd_tlp_valid, rd_tlp_last, rd_tlp_ready;
    logic        tlp_valid, tlp_ready, ack, nack;
    logic        wr_done, rd_done, wr_nack, rd_nack, spurious_err;
    logic [2:0]  outstanding;

    int total = 0;
    int bad   = 0;

    // Source driver queues: beat data and last flag, plus driver position.
    logic [31:0] wq_d[$];
    logic [31:0] rq_d[$];
    bit          wq_l[$];
    bit          rq_l[$];
    int          wpos, rpos;
    bit          rand_gate;

    // Link observation of the most recent cycle.
    bit in_pkt, xfer, xfer_src, xfer_last, pkt_start;

    tlp_link_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .DATA_WIDTH      (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_tlp_data  (wr_tlp_data),
        .wr_tlp_valid (wr_tlp_valid),
        .wr_tlp_last  (wr_tlp_last),
        .wr_tlp_ready (wr_tlp_ready),
        .rd_tlp_data  (rd_tlp_data),
        .rd_tlp_valid (rd_tlp_valid),
        .rd_tlp_last  (rd_tlp_last),
        .rd_tlp_ready (rd_tlp_ready),
        .tlp_data     (tlp_data),
        .tlp_valid    (tlp_valid),
        .tlp_ready    (tlp_ready),
        .ack          (ack),
        .nack         (nack),
        .wr_done      (wr_done),
        .rd_done      (rd_done),
        .wr_nack      (wr_nack),
        .rd_nack      (rd_nack),
        .outstanding  (outstanding),
        .spurious_err (spurious_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic push_pkt(input bit src, input logic [31:0] base, input int len);
        for (int b = 0; b < len; b++) begin
            logic [31:0] d;
            d     = base + 32'(b);
            d[31] = src;
            if (src) begin rq_d.push_back(d); rq_l.push_back(b == len - 1); end
            else     begin wq_d.push_back(d); wq_l.push_back(b == len - 1); end
        end
    endtask

    // One clock: drive inputs just after posedge, settle to negedge, observe.
    task automatic cycle(input bit a, input bit n, input bit r);
        @(posedge clk);
        #1;
        ack       = a;
        nack      = n;
        tlp_ready = r;
        if (wpos < wq_d.size()) begin
            wr_tlp_valid = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_tlp_data  = wq_d[wpos];
            wr_tlp_last  = wq_l[wpos];
        end else begin
            wr_tlp_valid = 1'b0; wr_tlp_data = '0; wr_tlp_last = 1'b0;
        end
        if (rpos < rq_d.size()) begin
            rd_tlp_valid = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_tlp_data  = rq_d[rpos];
            rd_tlp_last  = rq_l[rpos];
        end else begin
            rd_tlp_valid = 1'b0; rd_tlp_data = '0; rd_tlp_last = 1'b0;
        end
        @(negedge clk);
        xfer      = tlp_valid && tlp_ready;
        xfer_src  = tlp_data[31];
        xfer_last = xfer_src ? rd_tlp_last : wr_tlp_last;
        pkt_start = xfer && !in_pkt;
        if (xfer) in_pkt = !xfer_last;
        if (wr_tlp_valid && wr_tlp_ready) wpos++;
        if (rd_tlp_valid && rd_tlp_ready) rpos++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        ack = 1'b0; nack = 1'b0; tlp_ready = 1'b0;
        wr_tlp_valid = 1'b0; wr_tlp_data = '0; wr_tlp_last = 1'b0;
        rd_tlp_valid = 1'b0; rd_tlp_data = '0; rd_tlp_last = 1'b0;
        wq_d.delete(); wq_l.delete(); rq_d.delete(); rq_l.delete();
        wpos = 0; rpos = 0; in_pkt = 1'b0; rand_gate = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0; wr_tlp_valid = 1'b1; rd_tlp_valid = 1'b1; ack = 1'b1; tlp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({tlp_valid, wr_tlp_ready, rd_tlp_ready, wr_done, wr_nack, rd_done, rd_nack, spurious_err} !== 8'h00) begin
                bad++;
                $display("FAIL reset_ctrl: got %b want 00000000",
                         {tlp_valid, wr_tlp_ready, rd_tlp_ready, wr_done, wr_nack, rd_done, rd_nack, spurious_err});
            end
        end
        total++;
        if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++;
        if (tlp_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", tlp_data); end
        do_reset();
        cycle(0, 0, 0);
        total++;
        if ({tlp_valid, outstanding} !== 4'h0) begin bad++; $display("FAIL reset_release: got %b want 0000", {tlp_valid, outstanding}); end
    endtask

    task automatic test_single_write();
        logic [31:0] exp_beat [3];
        exp_beat[0] = 32'h11; exp_beat[1] = 32'h22; exp_beat[2] = 32'h33;
        do_reset();
        for (int i = 0; i < 3; i++) begin wq_d.push_back(exp_beat[i]); wq_l.push_back(i == 2); end
        cycle(0, 0, 1);
        total++;
        if (tlp_valid !== 1'b0) begin bad++; $display("FAIL sw_latency: got valid=%b want 0", tlp_valid); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            total++;
            if ({tlp_valid, wr_tlp_ready, tlp_data} !== {2'b11, exp_beat[i]}) begin
                bad++; $display("FAIL sw_beat%0d: got v=%b rdy=%b d=%h want v=1 rdy=1 d=%h", i, tlp_valid, wr_tlp_ready, tlp_data, exp_beat[i]);
            end
            total++;
            if (outstanding !== ((i == 0) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL sw_out%0d: got %0d want %0d", i, outstanding, (i == 0) ? 0 : 1); end
        end
        cycle(0, 0, 1);
        total++;
        if ({tlp_valid, outstanding} !== 4'b0001) begin bad++; $display("FAIL sw_idle: got %b want 0001", {tlp_valid, outstanding}); end
        cycle(1, 0, 1);
        total++;
        if ({wr_done, wr_nack, rd_done, rd_nack, spurious_err} !== 5'b10000) begin
            bad++; $display("FAIL sw_done: got %b want 10000", {wr_done, wr_nack, rd_done, rd_nack, spurious_err});
        end
        cycle(0, 0, 1);
        total++;
        if ({wr_done, outstanding} !== 4'b0000) begin bad++; $display("FAIL sw_retired: got %b want 0000", {wr_done, outstanding}); end
    endtask

    task automatic test_round_robin();
        bit order[$];
        bit a_next;
        bit exp_src;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pkt(1'b0, 32'h100 + 32'(i * 16), 2);
            push_pkt(1'b1, 32'h100 + 32'(i * 16), 2);
        end
        a_next = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cycle(a_next, 0, 1);
            a_next = xfer && xfer_last;
            if (pkt_start) order.push_back(xfer_src);
        end
        total++;
        if (order.size() != 8) begin bad++; $display("FAIL rr_count: got %0d packets want 8", order.size()); end
        for (int i = 0; i < 8 && i < order.size(); i++) begin
`ifdef TLP_ARB_WR_PRIO_EN
            exp_src = (i >= 4);
`else
            exp_src = (i % 2 == 1);
`endif
            total++;
            if (order[i] !== exp_src) begin bad++; $display("FAIL rr_order%0d: got src %0d want src %0d", i, order[i], exp_src); end
        end
        total++;
        if (outstanding !== 3'd0) begin bad++; $display("FAIL rr_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_full();
        int launches;
        int leaks;
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(1'b0, 32'h200 + 32'(i * 16), 2);
        launches = 0;
        repeat (30) begin
            cycle(0, 0, 1);
            if (pkt_start) launches++;
        end
        total++;
        if (launches != 4) begin bad++; $display("FAIL full_launches: got %0d want 4", launches); end
        total++;
        if (outstanding !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", outstanding); end
        leaks = 0;
        repeat (10) begin
            cycle(0, 0, 1);
            if (wr_tlp_ready || tlp_valid) leaks++;
        end
        total++;
        if (leaks != 0) begin bad++; $display("FAIL full_blocked: got %0d granted cycles want 0", leaks); end
        cycle(1, 0, 1);
        total++;
        if ({wr_done, outstanding} !== 4'b1100) begin bad++; $display("FAIL full_ack: got %b want 1100", {wr_done, outstanding}); end
        cycle(0, 0, 1);
        total++;
        if ({tlp_valid, outstanding} !== 4'b0011) begin bad++; $display("FAIL full_credit: got %b want 0011", {tlp_valid, outstanding}); end
        cycle(0, 0, 1);
        total++;
        if ({tlp_valid, tlp_data} !== {1'b1, 32'h240}) begin bad++; $display("FAIL full_fifth: got v=%b d=%h want v=1 d=00000240", tlp_valid, tlp_data); end
        cycle(0, 0, 1);
        total++;
        if (outstanding !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d want 4", outstanding); end
    endtask

    task automatic test_retire_order();
        logic [3:0] vec;
        do_reset();
        push_pkt(1'b0, 32'h300, 1); repeat (4) cycle(0, 0, 1);
        push_pkt(1'b1, 32'h310, 1); repeat (4) cycle(0, 0, 1);
        push_pkt(1'b0, 32'h320, 1); repeat (4) cycle(0, 0, 1);
        total++;
        if (outstanding !== 3'd3) begin bad++; $display("FAIL ro_count: got %0d want 3", outstanding); end
        cycle(0, 1, 1);
        vec = {wr_done, wr_nack, rd_done, rd_nack};
        total++;
        if (vec !== 4'b0100) begin bad++; $display("FAIL ro_first: got %b want 0100", vec); end
        cycle(1, 0, 1);
        vec = {wr_done, wr_nack, rd_done, rd_nack};
        total++;
        if ({vec, outstanding} !== {4'b0010, 3'd2}) begin bad++; $display("FAIL ro_second: got %b/%0d want 0010/2", vec, outstanding); end
        cycle(0, 1, 1);
        vec = {wr_done, wr_nack, rd_done, rd_nack};
        total++;
        if ({vec, outstanding} !== {4'b0100, 3'd1}) begin bad++; $display("FAIL ro_third: got %b/%0d want 0100/1", vec, outstanding); end
        cycle(0, 0, 1);
        vec = {wr_done, wr_nack, rd_done, rd_nack};
        total++;
        if ({vec, outstanding} !== {4'b0000, 3'd0}) begin bad++; $display("FAIL ro_empty: got %b/%0d want 0000/0", vec, outstanding); end
    endtask

    task automatic test_spurious();
        do_reset();
        cycle(1, 0, 1);
        total++;
        if ({spurious_err, wr_done, rd_done, outstanding} !== 6'b100000) begin
            bad++; $display("FAIL sp_pulse: got %b want 100000", {spurious_err, wr_done, rd_done, outstanding});
        end
        cycle(0, 0, 1);
        total++;
        if (spurious_err !== 1'b0) begin bad++; $display("FAIL sp_oneshot: got %b want 0", spurious_err); end
        push_pkt(1'b1, 32'h350, 1);
        repeat (4) cycle(0, 0, 1);
        total++;
        if (outstanding !== 3'd1) begin bad++; $display("FAIL sp_launch: got %0d want 1", outstanding); end
        cycle(1, 1, 1);
        total++;
        if ({wr_done, wr_nack, rd_done, rd_nack, spurious_err} !== 5'b00010) begin
            bad++; $display("FAIL sp_both: got %b want 00010", {wr_done, wr_nack, rd_done, rd_nack, spurious_err});
        end
        cycle(1, 0, 1);
        total++;
        if ({spurious_err, rd_done, outstanding} !== 5'b10000) begin
            bad++; $display("FAIL sp_single_pop: got %b want 10000", {spurious_err, rd_done, outstanding});
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        push_pkt(1'b0, 32'h400, 3);
        push_pkt(1'b1, 32'h400, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        total++;
        if ({tlp_valid, tlp_data} !== {1'b1, 32'h400}) begin bad++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=00000400", tlp_valid, tlp_data); end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0);
            total++;
            if ({tlp_valid, tlp_data, wr_tlp_ready, rd_tlp_ready} !== {1'b1, 32'h401, 2'b00}) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b d=%h wr=%b rd=%b want v=1 d=00000401 wr=0 rd=0", i, tlp_valid, tlp_data, wr_tlp_ready, rd_tlp_ready);
            end
        end
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        total++;
        if ({tlp_data, in_pkt} !== {32'h402, 1'b0}) begin bad++; $display("FAIL bp_last: got d=%h open=%b want d=00000402 open=0", tlp_data, in_pkt); end
        cycle(0, 0, 1);
        total++;
        if (tlp_valid !== 1'b0) begin bad++; $display("FAIL bp_gap: got valid=%b want 0", tlp_valid); end
        cycle(0, 0, 1);
        total++;
        if ({tlp_data, rd_tlp_ready, wr_tlp_ready} !== {32'h80000400, 2'b10}) begin
            bad++; $display("FAIL bp_read: got d=%h rd=%b wr=%b want d=80000400 rd=1 wr=0", tlp_data, rd_tlp_ready, wr_tlp_ready);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(1'b0, 32'h500, 4);
        repeat (3) cycle(0, 0, 1);
        total++;
        if ({tlp_valid, outstanding} !== 4'b1001) begin bad++; $display("FAIL rm_before: got %b want 1001", {tlp_valid, outstanding}); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({tlp_valid, wr_tlp_ready, outstanding} !== 5'b00000) begin
            bad++; $display("FAIL rm_async: got %b want 00000", {tlp_valid, wr_tlp_ready, outstanding});
        end
        do_reset();
        cycle(0, 0, 1);
        total++;
        if ({tlp_valid, outstanding} !== 4'b0000) begin bad++; $display("FAIL rm_after: got %b want 0000", {tlp_valid, outstanding}); end
    endtask

    // Reference model: link packets must match the source packet lists in
    // order, never interleave, and each first beat adds a tag to an
    // in-order queue that ack/nack consume.
    task automatic test_random();
        bit          mtag[$];
        int          mcnt, ew, er, guard;
        bit          in_p, cur, s, a, n, r, lst, hsrc;
        int          sel;
        logic [3:0]  vec, exp_vec;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            int len_w, len_r;
            len_w = $urandom_range(1, 4);
            len_r = $urandom_range(1, 4);
            for (int b = 0; b < len_w; b++) begin wq_d.push_back({1'b0, 31'($urandom())}); wq_l.push_back(b == len_w - 1); end
            for (int b = 0; b < len_r; b++) begin rq_d.push_back({1'b1, 31'($urandom())}); rq_l.push_back(b == len_r - 1); end
        end
        rand_gate = 1'b1;
        mcnt = 0; ew = 0; er = 0; in_p = 1'b0; cur = 1'b0; guard = 0;
        while (!(ew == wq_d.size() && er == rq_d.size() && mcnt == 0) && guard < 6000) begin
            guard++;
            sel = $urandom_range(0, 7);
            a = (sel == 0) || (sel == 2);
            n = (sel == 1) || (sel == 2);
            if (ew == wq_d.size() && er == rq_d.size()) a = 1'b1;
            r = ($urandom_range(0, 3) != 0);
            cycle(a, n, r);

            total++;
            if (int'(outstanding) != mcnt) begin bad++; $display("FAIL rnd_count: got %0d want %0d", outstanding, mcnt); end

            vec = {wr_done, wr_nack, rd_done, rd_nack};
            if ((a || n) && mtag.size() > 0) begin
                hsrc    = mtag.pop_front();
                mcnt--;
                exp_vec = {!hsrc && !n, !hsrc && n, hsrc && !n, hsrc && n};
                total++;
                if ({vec, spurious_err} !== {exp_vec, 1'b0}) begin bad++; $display("FAIL rnd_retire: got %b want %b", {vec, spurious_err}, {exp_vec, 1'b0}); end
            end else begin
                total++;
                if ({vec, spurious_err} !== {4'b0000, a || n}) begin bad++; $display("FAIL rnd_noretire: got %b want %b", {vec, spurious_err}, {4'b0000, a || n}); end
            end

            if (tlp_valid && tlp_ready) begin
                s = tlp_data[31];
                total++;
                if (in_p && s != cur) begin bad++; $display("FAIL rnd_interleave: got src %0d want src %0d", s, cur); end
                if ((s && er >= rq_d.size()) || (!s && ew >= wq_d.size())) begin
                    total++; bad++;
                    $display("FAIL rnd_extra_beat: got beat %h want none", tlp_data);
                end else begin
                    exp_d = s ? rq_d[er] : wq_d[ew];
                    lst   = s ? rq_l[er] : wq_l[ew];
                    total++;
                    if (tlp_data !== exp_d) begin bad++; $display("FAIL rnd_data: got %h want %h", tlp_data, exp_d); end
                    total++;
                    if ({wr_tlp_ready, rd_tlp_ready} !== (s ? 2'b01 : 2'b10)) begin
                        bad++; $display("FAIL rnd_ready: got %b want %b", {wr_tlp_ready, rd_tlp_ready}, s ? 2'b01 : 2'b10);
                    end
                    if (!in_p) begin mtag.push_back(s); mcnt++; cur = s; in_p = 1'b1; end
                    if (lst) in_p = 1'b0;
                    if (s) er++; else ew++;
                end
            end
            total++;
            if (mcnt > MAXO) begin bad++; $display("FAIL rnd_credit: got %0d in flight want <= %0d", mcnt, MAXO); end
        end
        total++;
        if (ew != wq_d.size() || er != rq_d.size() || mcnt != 0) begin
            bad++; $display("FAIL rnd_drain: got wr=%0d rd=%0d inflight=%0d want wr=%0d rd=%0d inflight=0", ew, er, mcnt, wq_d.size(), rq_d.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ack = 1'b0; nack = 1'b0; tlp_ready = 1'b0;
        wr_tlp_valid = 1'b0; wr_tlp_data = '0; wr_tlp_last = 1'b0;
        rd_tlp_valid = 1'b0; rd_tlp_data = '0; rd_tlp_last = 1'b0;
        wpos = 0; rpos = 0; rand_gate = 1'b0; in_pkt = 1'b0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_full();
        test_retire_order();
        test_spurious();
        test_back_pressure();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
